// File: rtl/sprite_types.sv
// Shared sprite pipeline types: matcher descriptors and the per-line fetch FSM encoding.
package sprite_types;

  localparam int SPR_ADDR_W    = 18;
  localparam int TILE_COUNT_W  = 6;
  localparam int LB_X_W        = 11;
  localparam int SPR_IDX_W     = 9;
  localparam int TILE_PX_WIDTH = 16;  // 8 pixels, each doubled on screen

  typedef struct packed {
    logic                    x_flip;
    logic [TILE_COUNT_W-1:0] tile_count;
    logic [SPR_ADDR_W-1:0]   tilemap_addr;
  } active_tilemap_addr_t;

  typedef struct packed {
    logic [LB_X_W-1:0]     lb_addr;
    logic [SPR_ADDR_W-1:0] tile_bitmap_addr;
  } active_bitmap_addr_t;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_WAIT_IDX,
    FS_CHECK,
    FS_TMAP,
    FS_BMAP,
    FS_PUSH
  } fetch_state_t;

  function automatic logic [SPR_IDX_W-1:0] idx_sat_inc(input logic [SPR_IDX_W-1:0] idx);
    return (idx == '1) ? idx : idx + 1'b1;
  endfunction

endpackage

// File: rtl/sprite_fetch_sequencer.sv
// Per-scanline sprite fetcher: walks the active list, reads tilemap then bitmap per tile, pushes rows.
// One row per 3 cycles with zero-wait VRAM/line buffer; req and push held until ack/ready.
module sprite_fetch_sequencer
  import sprite_types::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32,
  parameter int TILE_IDX_W  = 10,
  parameter int IDX_LATENCY = 1
) (
  input  logic                 clk_draw,
  input  logic                 rst_draw_n,
  input  logic                 line,
  input  logic                 enable,
  output logic [SPR_IDX_W-1:0] sprite_index,
  input  logic                 valid,
  input  active_tilemap_addr_t tilemap_addr,
  input  active_bitmap_addr_t  bitmap_addr,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 lb_valid,
  input  logic                 lb_ready,
  output logic [LB_X_W-1:0]    lb_x,
  output logic [DATA_W-1:0]    lb_data,
  output logic                 lb_flip,
  output logic                 busy,
  output logic                 overrun
);

  localparam int WAIT_LAST = (IDX_LATENCY > 0) ? IDX_LATENCY - 1 : 0;

  fetch_state_t            state, state_nxt;
  logic [7:0]              wait_cnt;
  logic [ADDR_W-1:0]       tmap_word, bmap_base, first_word;
  logic [TILE_COUNT_W-1:0] tiles_left;
  logic [TILE_IDX_W-1:0]   tile;
  logic [LB_X_W-1:0]       x_r;
  logic                    flip_r;
  logic                    restart_pend, restart_en, restart_go;
  logic                    do_restart, do_advance, desc_load, tile_load, data_load;
  logic                    push_step, pend_set, wait_done;

  assign busy      = (state != FS_IDLE);
  assign lb_x      = x_r;
  assign lb_flip   = flip_r;
  assign wait_done = (wait_cnt >= 8'(WAIT_LAST));
  assign first_word = tilemap_addr.x_flip
                    ? ADDR_W'(tilemap_addr.tilemap_addr + SPR_ADDR_W'(tilemap_addr.tile_count)
                              - SPR_ADDR_W'(1))
                    : ADDR_W'(tilemap_addr.tilemap_addr);

  always_comb begin
    state_nxt  = state;
    do_restart = 1'b0;
    do_advance = 1'b0;
    desc_load  = 1'b0;
    tile_load  = 1'b0;
    data_load  = 1'b0;
    push_step  = 1'b0;
    pend_set   = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    lb_valid   = 1'b0;
    // a fresh line overrides any enable remembered from an earlier one
    restart_go = line ? enable : restart_en;
    case (state)
      FS_IDLE: if (line && enable) do_restart = 1'b1;
      FS_WAIT_IDX: begin
        if (line) do_restart = 1'b1;
        else if (wait_done) state_nxt = FS_CHECK;
      end
      FS_CHECK: begin
        if (line) do_restart = 1'b1;
        else if (!valid) state_nxt = FS_IDLE;
        else if (tilemap_addr.tile_count == '0) do_advance = 1'b1;
        else begin
          desc_load = 1'b1;
          state_nxt = FS_TMAP;
        end
      end
      FS_TMAP: begin
        mem_req  = 1'b1;
        mem_addr = tmap_word;
        if (mem_ack) begin
          if (line || restart_pend) do_restart = 1'b1;
          else begin
            tile_load = 1'b1;
            state_nxt = FS_BMAP;
          end
        end else if (line) pend_set = 1'b1;
      end
      FS_BMAP: begin
        mem_req  = 1'b1;
        mem_addr = bmap_base + ADDR_W'(tile);
        if (mem_ack) begin
          if (line || restart_pend) do_restart = 1'b1;
          else begin
            data_load = 1'b1;
            state_nxt = FS_PUSH;
          end
        end else if (line) pend_set = 1'b1;
      end
      FS_PUSH: begin
        lb_valid = 1'b1;
        if (line) do_restart = 1'b1;
        else if (lb_ready) begin
          push_step = 1'b1;
          if (tiles_left == TILE_COUNT_W'(1)) do_advance = 1'b1;
          else state_nxt = FS_TMAP;
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
    // the last list slot has no successor, so the line ends there
    if (do_advance) state_nxt = (sprite_index == '1) ? FS_IDLE : FS_WAIT_IDX;
    if (do_restart) state_nxt = restart_go ? FS_WAIT_IDX : FS_IDLE;
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state   <= FS_IDLE;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= line && busy;
    end
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      sprite_index <= '0;
      wait_cnt     <= '0;
      restart_pend <= 1'b0;
      restart_en   <= 1'b0;
      tmap_word    <= '0;
      bmap_base    <= '0;
      tiles_left   <= '0;
      tile         <= '0;
      x_r          <= '0;
      flip_r       <= 1'b0;
      lb_data      <= '0;
    end else begin
      if (do_restart) sprite_index <= '0;
      else if (do_advance) sprite_index <= idx_sat_inc(sprite_index);

      if (do_restart || do_advance) wait_cnt <= '0;
      else if (state == FS_WAIT_IDX) wait_cnt <= wait_cnt + 8'd1;

      if (do_restart) restart_pend <= 1'b0;
      else if (pend_set) begin
        restart_pend <= 1'b1;
        restart_en   <= enable;
      end

      if (desc_load) begin
        flip_r     <= tilemap_addr.x_flip;
        tiles_left <= tilemap_addr.tile_count;
        x_r        <= bitmap_addr.lb_addr;
        bmap_base  <= ADDR_W'(bitmap_addr.tile_bitmap_addr);
        tmap_word  <= first_word;
      end else if (push_step) begin
        x_r        <= x_r + LB_X_W'(TILE_PX_WIDTH);
        tmap_word  <= flip_r ? tmap_word - ADDR_W'(1) : tmap_word + ADDR_W'(1);
        tiles_left <= tiles_left - TILE_COUNT_W'(1);
      end

      if (tile_load) tile <= mem_rdata[TILE_IDX_W-1:0];
      if (data_load) lb_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Bench for sprite_fetch_sequencer: matcher/VRAM/line-buffer models plus a list-level reference.
module tb_sprite_fetch_sequencer;
  import sprite_types::*;

  logic                 clk_draw = 1'b0;
  logic                 rst_draw_n = 1'b0;
  logic                 line = 1'b0;
  logic                 enable = 1'b0;
  logic [8:0]           sprite_index;
  logic                 valid = 1'b0;
  active_tilemap_addr_t tilemap_addr = '0;
  active_bitmap_addr_t  bitmap_addr = '0;
  logic                 mem_req;
  logic [17:0]          mem_addr;
  logic                 mem_ack = 1'b0;
  logic [31:0]          mem_rdata = '0;
  logic                 lb_valid;
  logic                 lb_ready = 1'b0;
  logic [10:0]          lb_x;
  logic [31:0]          lb_data;
  logic                 lb_flip;
  logic                 busy;
  logic                 overrun;

  always #5 clk_draw = ~clk_draw;

  sprite_fetch_sequencer #(.ADDR_W(18), .DATA_W(32), .TILE_IDX_W(10), .IDX_LATENCY(1)) dut (
    .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .line(line), .enable(enable),
    .sprite_index(sprite_index), .valid(valid), .tilemap_addr(tilemap_addr),
    .bitmap_addr(bitmap_addr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .lb_valid(lb_valid), .lb_ready(lb_ready), .lb_x(lb_x),
    .lb_data(lb_data), .lb_flip(lb_flip), .busy(busy), .overrun(overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sprite list seen by the matcher and VRAM contents
  active_tilemap_addr_t spr_tm [16];
  active_bitmap_addr_t  spr_bm [16];
  int                   n_spr = 0;
  logic [31:0]          vram_ovr [int];

  function automatic logic [31:0] vram_word(input logic [17:0] a);
    if (vram_ovr.exists(int'(a))) return vram_ovr[int'(a)];
    return {a[9:0], 4'h0, a} ^ 32'hC3A5_9E17;
  endfunction

  always @(negedge clk_draw) begin
    if (int'(sprite_index) < n_spr) begin
      valid        = 1'b1;
      tilemap_addr = spr_tm[sprite_index[3:0]];
      bitmap_addr  = spr_bm[sprite_index[3:0]];
    end else begin
      valid        = 1'b0;
      tilemap_addr = '0;
      bitmap_addr  = '0;
    end
  end

  // VRAM responder
  int          stall_q [$];
  int          mem_stall_max = 0;
  int          lb_stall_max = 0;
  int          req_cycles = 0;
  logic [17:0] act_rd [$];
  logic [10:0] act_px [$];
  logic [31:0] act_pd [$];
  logic        act_pf [$];
  bit          m_busy = 0;
  int          m_stall = 0;
  logic [17:0] m_addr = '0;

  always @(negedge clk_draw) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!rst_draw_n || !mem_req) m_busy = 0;
    else begin
      req_cycles++;
      if (!m_busy) begin
        m_busy = 1;
        m_addr = mem_addr;
        if (stall_q.size() != 0) m_stall = stall_q.pop_front();
        else m_stall = int'($urandom_range(mem_stall_max, 0));
      end else chk("mem_addr_stable", 64'(mem_addr), 64'(m_addr));
      if (m_stall == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = vram_word(mem_addr);
        act_rd.push_back(mem_addr);
        m_busy = 0;
      end else m_stall--;
    end
  end

  // line-buffer responder
  bit          l_busy = 0;
  int          l_stall = 0;
  logic [10:0] l_x = '0;
  logic [31:0] l_d = '0;
  logic        l_f = 1'b0;

  always @(negedge clk_draw) begin
    lb_ready = 1'b0;
    if (!rst_draw_n || !lb_valid) l_busy = 0;
    else begin
      if (!l_busy) begin
        l_busy  = 1;
        l_x     = lb_x;
        l_d     = lb_data;
        l_f     = lb_flip;
        l_stall = int'($urandom_range(lb_stall_max, 0));
      end else begin
        chk("lb_x_stable", 64'(lb_x), 64'(l_x));
        chk("lb_data_stable", 64'(lb_data), 64'(l_d));
        chk("lb_flip_stable", 64'(lb_flip), 64'(l_f));
      end
      if (l_stall == 0) begin
        lb_ready = 1'b1;
        act_px.push_back(lb_x);
        act_pd.push_back(lb_data);
        act_pf.push_back(lb_flip);
        l_busy = 0;
      end else l_stall--;
    end
  end

  // reference: expected VRAM reads, pushes and zero-wait line length for the current list
  logic [17:0] exp_rd [$];
  logic [10:0] exp_px [$];
  logic [31:0] exp_pd [$];
  logic        exp_pf [$];
  int          exp_cycles = 0;

  task automatic build_expected();
    int          tiles;
    int          cnt;
    logic [17:0] w;
    logic [17:0] b;
    logic [31:0] tw;
    tiles = 0;
    for (int i = 0; i < n_spr; i++) begin
      cnt = int'(spr_tm[i].tile_count);
      for (int t = 0; t < cnt; t++) begin
        w  = spr_tm[i].x_flip ? spr_tm[i].tilemap_addr + 18'(cnt - 1 - t)
                              : spr_tm[i].tilemap_addr + 18'(t);
        tw = vram_word(w);
        b  = spr_bm[i].tile_bitmap_addr + 18'(tw[9:0]);
        exp_rd.push_back(w);
        exp_rd.push_back(b);
        exp_px.push_back(11'((int'(spr_bm[i].lb_addr) + 16 * t) % 2048));
        exp_pd.push_back(vram_word(b));
        exp_pf.push_back(spr_tm[i].x_flip);
      end
      tiles += cnt;
    end
    exp_cycles = 2 * (n_spr + 1) + 3 * tiles;
  endtask

  task automatic clear_logs();
    act_rd.delete(); act_px.delete(); act_pd.delete(); act_pf.delete();
    exp_rd.delete(); exp_px.delete(); exp_pd.delete(); exp_pf.delete();
    req_cycles = 0;
  endtask

  task automatic compare_logs(input string tag);
    chk({tag, "_nreads"}, 64'(act_rd.size()), 64'(exp_rd.size()));
    for (int k = 0; k < exp_rd.size() && k < act_rd.size(); k++)
      chk({tag, "_read_addr"}, 64'(act_rd[k]), 64'(exp_rd[k]));
    chk({tag, "_npush"}, 64'(act_px.size()), 64'(exp_px.size()));
    for (int k = 0; k < exp_px.size() && k < act_px.size(); k++) begin
      chk({tag, "_push_x"}, 64'(act_px[k]), 64'(exp_px[k]));
      chk({tag, "_push_data"}, 64'(act_pd[k]), 64'(exp_pd[k]));
      chk({tag, "_push_flip"}, 64'(act_pf[k]), 64'(exp_pf[k]));
    end
  endtask

  task automatic run_line(input logic en, output int cyc);
    @(negedge clk_draw);
    line   = 1'b1;
    enable = en;
    @(negedge clk_draw);
    line = 1'b0;
    cyc  = 0;
    while (busy && cyc < 5000) begin
      cyc++;
      @(negedge clk_draw);
    end
    chk("line_done", 64'(busy), 64'd0);
  endtask

  int cyc;
  int guard;
  logic [17:0] b0;

  initial begin
    // reset values
    repeat (3) @(negedge clk_draw);
    chk("rst_sprite_index", 64'(sprite_index), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_lb_valid", 64'(lb_valid), 64'd0);
    chk("rst_lb_x", 64'(lb_x), 64'd0);
    chk("rst_lb_data", 64'(lb_data), 64'd0);
    chk("rst_lb_flip", 64'(lb_flip), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst_draw_n = 1'b1;

    // line with sprites disabled stays idle
    n_spr = 1;
    spr_tm[0] = '{x_flip: 1'b0, tile_count: 6'd2, tilemap_addr: 18'h100};
    spr_bm[0] = '{lb_addr: 11'd40, tile_bitmap_addr: 18'h2000};
    clear_logs();
    run_line(1'b0, cyc);
    chk("disabled_cycles", 64'(cyc), 64'd0);
    chk("disabled_req", 64'(req_cycles), 64'd0);

    // empty list: IDLE again on the third edge, no VRAM traffic
    n_spr = 0;
    clear_logs();
    run_line(1'b1, cyc);
    chk("empty_cycles", 64'(cyc), 64'd2);
    chk("empty_req", 64'(req_cycles), 64'd0);

    // one sprite, two tiles
    n_spr = 1;
    vram_ovr[32'h100] = 32'd5;
    vram_ovr[32'h101] = 32'd7;
    clear_logs();
    build_expected();
    run_line(1'b1, cyc);
    compare_logs("one");
    chk("one_rd0", 64'(act_rd[0]), 64'h100);
    chk("one_rd1", 64'(act_rd[1]), 64'h2005);
    chk("one_rd2", 64'(act_rd[2]), 64'h101);
    chk("one_rd3", 64'(act_rd[3]), 64'h2007);
    chk("one_x0", 64'(act_px[0]), 64'd40);
    chk("one_x1", 64'(act_px[1]), 64'd56);
    chk("one_cycles", 64'(cyc), 64'(exp_cycles));

    // x_flip walks the tilemap backwards
    spr_tm[0] = '{x_flip: 1'b1, tile_count: 6'd3, tilemap_addr: 18'h200};
    spr_bm[0] = '{lb_addr: 11'd100, tile_bitmap_addr: 18'h3000};
    clear_logs();
    build_expected();
    run_line(1'b1, cyc);
    compare_logs("flip");
    chk("flip_rd0", 64'(act_rd[0]), 64'h202);
    chk("flip_rd2", 64'(act_rd[2]), 64'h201);
    chk("flip_rd4", 64'(act_rd[4]), 64'h200);
    chk("flip_lb_flip", 64'(act_pf[0]), 64'd1);
    chk("flip_cycles", 64'(cyc), 64'(exp_cycles));

    // zero-tile sprite between two real ones is skipped
    n_spr = 3;
    spr_tm[0] = '{x_flip: 1'b0, tile_count: 6'd1, tilemap_addr: 18'h300};
    spr_bm[0] = '{lb_addr: 11'd8, tile_bitmap_addr: 18'h1000};
    spr_tm[1] = '{x_flip: 1'b0, tile_count: 6'd0, tilemap_addr: 18'h400};
    spr_bm[1] = '{lb_addr: 11'd80, tile_bitmap_addr: 18'h1400};
    spr_tm[2] = '{x_flip: 1'b1, tile_count: 6'd1, tilemap_addr: 18'h500};
    spr_bm[2] = '{lb_addr: 11'd2040, tile_bitmap_addr: 18'h3FFF0};
    clear_logs();
    build_expected();
    run_line(1'b1, cyc);
    compare_logs("skip");
    chk("skip_nreads", 64'(act_rd.size()), 64'd4);
    chk("skip_cycles", 64'(cyc), 64'(exp_cycles));

    // random lists with random VRAM and line-buffer stalls
    mem_stall_max = 5;
    lb_stall_max  = 5;
    for (int r = 0; r < 8; r++) begin
      n_spr = int'($urandom_range(5, 1));
      for (int i = 0; i < n_spr; i++) begin
        spr_tm[i].x_flip           = 1'($urandom_range(1, 0));
        spr_tm[i].tile_count       = 6'($urandom_range(3, 0));
        spr_tm[i].tilemap_addr     = 18'($urandom);
        spr_bm[i].lb_addr          = 11'($urandom);
        spr_bm[i].tile_bitmap_addr = 18'($urandom);
      end
      clear_logs();
      build_expected();
      run_line(1'b1, cyc);
      compare_logs("rnd");
    end

    // line arrives during the bitmap read; the read completes, then the list restarts
    mem_stall_max = 0;
    lb_stall_max  = 0;
    n_spr = 1;
    spr_tm[0] = '{x_flip: 1'b0, tile_count: 6'd1, tilemap_addr: 18'h600};
    spr_bm[0] = '{lb_addr: 11'd200, tile_bitmap_addr: 18'h3FFF0};
    clear_logs();
    b0 = spr_bm[0].tile_bitmap_addr + 18'(vram_word(18'h600) & 32'h3FF);
    exp_rd.push_back(18'h600);
    exp_rd.push_back(b0);
    build_expected();
    stall_q.push_back(0);
    stall_q.push_back(4);
    @(negedge clk_draw);
    line   = 1'b1;
    enable = 1'b1;
    @(negedge clk_draw);
    line  = 1'b0;
    guard = 0;
    while (!(mem_req && mem_addr == b0) && guard < 20) begin
      guard++;
      @(negedge clk_draw);
    end
    chk("ovr_reached_bmap", 64'(mem_req && mem_addr == b0), 64'd1);
    line = 1'b1;
    @(negedge clk_draw);
    line = 1'b0;
    chk("ovr_pulse", 64'(overrun), 64'd1);
    chk("ovr_req_held", 64'(mem_req), 64'd1);
    @(negedge clk_draw);
    chk("ovr_pulse_end", 64'(overrun), 64'd0);
    guard = 0;
    while (busy && guard < 200) begin
      guard++;
      @(negedge clk_draw);
    end
    chk("ovr_done", 64'(busy), 64'd0);
    compare_logs("ovr");

    // reset during a stalled tilemap read aborts everything
    clear_logs();
    stall_q.push_back(5);
    @(negedge clk_draw);
    line = 1'b1;
    @(negedge clk_draw);
    line  = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin
      guard++;
      @(negedge clk_draw);
    end
    @(negedge clk_draw);
    rst_draw_n = 1'b0;
    #1;
    chk("arst_mem_req", 64'(mem_req), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_sprite_index", 64'(sprite_index), 64'd0);
    chk("arst_lb_x", 64'(lb_x), 64'd0);
    @(negedge clk_draw);
    rst_draw_n = 1'b1;
    stall_q.delete();
    clear_logs();
    build_expected();
    run_line(1'b1, cyc);
    compare_logs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
